// File: rtl/dvi_capture.sv
// rtl/dvi_capture.sv - DDR DVI receive path: pixel rebuild, sync re-timing, mode measurement
//
// Rebuilds 24-bit RGB from the rising/falling DDR halves of the 12-bit DVI bus,
// re-times sync/de with a fixed two-register latency, tracks pixel coordinates
// and measures the incoming timing to report a stable (locked) mode.
//
// Ports:
//   gpu_clk0                     pixel clock
//   Rst                          asynchronous active-high reset
//   hsync_in, vsync_in, de_in    raw sync / data enable (sync polarity set by SYNC_ACTIVE_LOW)
//   dvi_data_a                   rising-edge half  {green[3:0], blue[7:0]}
//   dvi_data_b                   falling-edge half {red[7:0], green[7:4]}
//   red_out, green_out, blue_out reconstructed pixel
//   hsync_out, vsync_out, de_out re-timed sync/enable, original polarity
//   sof_out                      first de pixel of a frame
//   pix_x, pix_y                 coordinates of the current de_out pixel
//   h_total, h_active            published line length / active width (cycles)
//   v_total, v_active            published frame height / active height (lines)
//   locked                       measurements repeated for LOCK_FRAMES frames
//   timeout                      one-cycle pulse on loss of hsync
module dvi_capture #(
  parameter int CW              = 12,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 3,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic          gpu_clk0,
  input  logic          Rst,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          de_in,
  input  logic [11:0]   dvi_data_a,
  input  logic [11:0]   dvi_data_b,
  output logic [7:0]    red_out,
  output logic [7:0]    green_out,
  output logic [7:0]    blue_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          de_out,
  output logic          sof_out,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic          locked,
  output logic          timeout
);

  localparam logic          SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam int            MW        = $clog2(LOCK_FRAMES + 1);
  localparam logic [MW-1:0] LOCK_MAX  = MW'(LOCK_FRAMES);
  localparam int            IW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Stage 1 input registers and their delayed copies for edge detection.
  logic        s1_hs, s1_vs, s1_de;
  logic [11:0] s1_a, s1_b;
  logic        d_hs, d_vs, d_de;

  always_ff @(posedge gpu_clk0 or posedge Rst) begin
    if (Rst) begin
      s1_hs <= SYNC_IDLE;
      s1_vs <= SYNC_IDLE;
      s1_de <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      d_hs  <= SYNC_IDLE;
      d_vs  <= SYNC_IDLE;
      d_de  <= 1'b0;
    end else begin
      s1_hs <= hsync_in;
      s1_vs <= vsync_in;
      s1_de <= de_in;
      s1_a  <= dvi_data_a;
      s1_b  <= dvi_data_b;
      d_hs  <= s1_hs;
      d_vs  <= s1_vs;
      d_de  <= s1_de;
    end
  end

  // Syncs are normalised to active-high before edge detection.
  logic hs_act, hs_act_d, vs_act, vs_act_d;
  logic hs_lead, vs_lead, de_rise, de_fall;

  assign hs_act   = s1_hs ^ SYNC_IDLE;
  assign hs_act_d = d_hs ^ SYNC_IDLE;
  assign vs_act   = s1_vs ^ SYNC_IDLE;
  assign vs_act_d = d_vs ^ SYNC_IDLE;
  assign hs_lead  = hs_act & ~hs_act_d;
  assign vs_lead  = vs_act & ~vs_act_d;
  assign de_rise  = s1_de & ~d_de;
  assign de_fall  = ~s1_de & d_de;

  // Stage 2: decoded pixel, re-timed syncs, coordinates and registered edges.
  logic line_seen;   // a de line has already started in this frame
  logic sof_armed;   // vs_lead seen, waiting for the next de_rise
  logic hs_lead_r, vs_lead_r, de_rise_r, de_fall_r;

  always_ff @(posedge gpu_clk0 or posedge Rst) begin
    if (Rst) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
      de_out    <= 1'b0;
      sof_out   <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      line_seen <= 1'b0;
      sof_armed <= 1'b0;
      hs_lead_r <= 1'b0;
      vs_lead_r <= 1'b0;
      de_rise_r <= 1'b0;
      de_fall_r <= 1'b0;
    end else begin
      red_out   <= s1_b[11:4];
      green_out <= {s1_b[3:0], s1_a[11:8]};
      blue_out  <= s1_a[7:0];
      hsync_out <= s1_hs;
      vsync_out <= s1_vs;
      de_out    <= s1_de;
      hs_lead_r <= hs_lead;
      vs_lead_r <= vs_lead;
      de_rise_r <= de_rise;
      de_fall_r <= de_fall;

      if (s1_de) begin
        pix_x <= de_rise ? '0 : sat_inc(pix_x);
      end

      // A de_rise coincident with vs_lead is the first line of the new frame.
      if (vs_lead) begin
        pix_y     <= '0;
        line_seen <= de_rise;
      end else if (de_rise) begin
        if (line_seen) begin
          pix_y <= sat_inc(pix_y);
        end
        line_seen <= 1'b1;
      end

      // A de run already in progress at vs_lead does not start the frame.
      sof_out <= de_rise & (sof_armed | vs_lead);
      if (de_rise) begin
        sof_armed <= 1'b0;
      end else if (vs_lead) begin
        sof_armed <= 1'b1;
      end
    end
  end

  // Measurement: working counters run off the registered edges so that the
  // published values land one cycle after the pixel outputs.
  logic [CW-1:0] hcnt, h_total_w;
  logic [CW-1:0] decnt, h_active_w;
  logic [CW-1:0] lines, aclines;
  logic [CW-1:0] lines_next, aclines_next;
  logic [MW-1:0] match_cnt;
  logic [IW-1:0] idle;
  logic          idle_hit;
  logic          all_match;

  // An hs_lead coincident with vs_lead belongs to the frame being closed.
  assign lines_next   = hs_lead_r ? sat_inc(lines) : lines;
  assign aclines_next = de_rise_r ? sat_inc(aclines) : aclines;
  assign all_match    = (h_total_w == h_total) && (h_active_w == h_active) &&
                        (lines_next == v_total) && (aclines_next == v_active);
  assign idle_hit     = !hs_lead_r && (idle == IDLE_LAST);
  assign locked       = (match_cnt == LOCK_MAX);

  always_ff @(posedge gpu_clk0 or posedge Rst) begin
    if (Rst) begin
      hcnt       <= '0;
      h_total_w  <= '0;
      decnt      <= '0;
      h_active_w <= '0;
      lines      <= '0;
      aclines    <= '0;
      h_total    <= '0;
      h_active   <= '0;
      v_total    <= '0;
      v_active   <= '0;
      match_cnt  <= '0;
      idle       <= '0;
      timeout    <= 1'b0;
    end else begin
      if (hs_lead_r) begin
        h_total_w <= hcnt;
        hcnt      <= CNT_ONE;
      end else begin
        hcnt <= sat_inc(hcnt);
      end

      if (de_out) begin
        decnt <= de_rise_r ? CNT_ONE : sat_inc(decnt);
      end
      if (de_fall_r) begin
        h_active_w <= decnt;
      end

      if (vs_lead_r) begin
        lines   <= '0;
        aclines <= '0;
      end else begin
        lines   <= lines_next;
        aclines <= aclines_next;
      end

      // Idle counter holds at its limit so the timeout fires only once.
      if (hs_lead_r) begin
        idle <= '0;
      end else if (idle != IDLE_MAX) begin
        idle <= idle + IW'(1);
      end
      timeout <= idle_hit;

      if (idle_hit) begin
        h_total   <= '0;
        h_active  <= '0;
        v_total   <= '0;
        v_active  <= '0;
        match_cnt <= '0;
      end else if (vs_lead_r) begin
        h_total  <= h_total_w;
        h_active <= h_active_w;
        v_total  <= lines_next;
        v_active <= aclines_next;
        if (all_match) begin
          if (match_cnt != LOCK_MAX) begin
            match_cnt <= match_cnt + MW'(1);
          end
        end else begin
          match_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvi_capture.sv
// tb/tb_dvi_capture.sv - directed self-checking bench for dvi_capture
module tb_dvi_capture;

  logic        gpu_clk0 = 1'b0;
  logic        Rst;
  logic        hsync_in, vsync_in, de_in;
  logic [11:0] dvi_data_a, dvi_data_b;

  logic [7:0]  red_out, green_out, blue_out;
  logic        hsync_out, vsync_out, de_out, sof_out, locked, timeout;
  logic [11:0] pix_x, pix_y, h_total, h_active, v_total, v_active;

  logic [7:0]  red_s, green_s, blue_s;
  logic        hsync_s, vsync_s, de_s, sof_s, locked_s, timeout_s;
  logic [11:0] pix_x_s, pix_y_s, h_total_s, h_active_s, v_total_s, v_active_s;

  int n_total = 0;
  int n_pass  = 0;
  int pulses;
  int first_pulse;

  dvi_capture #(.CW(12), .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(3), .TIMEOUT_CYCLES(100)) dut (
    .gpu_clk0(gpu_clk0), .Rst(Rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .dvi_data_a(dvi_data_a), .dvi_data_b(dvi_data_b),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out), .sof_out(sof_out),
    .pix_x(pix_x), .pix_y(pix_y), .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active), .locked(locked), .timeout(timeout)
  );

  dvi_capture #(.CW(12), .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(3), .TIMEOUT_CYCLES(65535)) dut_sat (
    .gpu_clk0(gpu_clk0), .Rst(Rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .dvi_data_a(dvi_data_a), .dvi_data_b(dvi_data_b),
    .red_out(red_s), .green_out(green_s), .blue_out(blue_s),
    .hsync_out(hsync_s), .vsync_out(vsync_s), .de_out(de_s), .sof_out(sof_s),
    .pix_x(pix_x_s), .pix_y(pix_y_s), .h_total(h_total_s), .h_active(h_active_s),
    .v_total(v_total_s), .v_active(v_active_s), .locked(locked_s), .timeout(timeout_s)
  );

  always #5 gpu_clk0 = ~gpu_clk0;

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge gpu_clk0);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Sync arguments are active-high; the bus is active-low.
  task automatic drive(input logic hs, input logic vs, input logic de,
                       input logic [11:0] a, input logic [11:0] b);
    hsync_in   = ~hs;
    vsync_in   = ~vs;
    de_in      = de;
    dvi_data_a = a;
    dvi_data_b = b;
  endtask

  // Ten lines of htot cycles: hsync on cycles 0-1, de on cycles 4..15 of
  // lines 2..7, vsync edge at line 0 cycle vpos lasting one line.
  task automatic run_frame(input int htot, input int vpos, input bit lock_rise);
    bit pv, pde, psof, de;
    int px, py;
    pv = 0; pde = 0; psof = 0; px = 0; py = 0;
    for (int l = 0; l < 10; l++) begin
      for (int c = 0; c < htot; c++) begin
        de = (l >= 2) && (l <= 7) && (c >= 4) && (c < 16);
        drive(c < 2, (l == 0 && c >= vpos) || (l == 1 && c < vpos), de,
              12'($urandom), 12'($urandom));
        tick();
        if (pv) begin
          check("de_out", {31'd0, de_out}, {31'd0, pde});
          check("sof_out", {31'd0, sof_out}, {31'd0, psof});
          if (pde) begin
            check("pix_x", {20'd0, pix_x}, px);
            check("pix_y", {20'd0, pix_y}, py);
          end
        end
        if (lock_rise && l == 0 && c == vpos + 1) check("locked_pre", {31'd0, locked}, 0);
        if (lock_rise && l == 0 && c == vpos + 2) check("locked_rise", {31'd0, locked}, 1);
        pv = 1; pde = de; psof = (l == 2 && c == 4); px = c - 4; py = l - 2;
      end
    end
  endtask

  task automatic check_meas(input string tag, input int ht, input int ha, input int vt,
                            input int va, input bit lk);
    check({tag, "_h_total"},  {20'd0, h_total},  ht);
    check({tag, "_h_active"}, {20'd0, h_active}, ha);
    check({tag, "_v_total"},  {20'd0, v_total},  vt);
    check({tag, "_v_active"}, {20'd0, v_active}, va);
    check({tag, "_locked"},   {31'd0, locked},   {31'd0, lk});
  endtask

  initial begin
    Rst = 1'b0;
    drive(0, 0, 0, 12'h000, 12'h000);
    #1 Rst = 1'b1;
    drive($urandom, $urandom, $urandom, 12'($urandom), 12'($urandom));
    #1;
    check("rst_rgb", {8'd0, red_out, green_out, blue_out}, 0);
    check("rst_syncs", {29'd0, hsync_out, vsync_out, de_out}, 32'h6);
    check("rst_pulses", {30'd0, sof_out, timeout}, 0);
    check("rst_pix", {8'd0, pix_x, pix_y}, 0);
    check_meas("rst", 0, 0, 0, 0, 0);
    repeat (3) begin
      drive($urandom, $urandom, $urandom, 12'($urandom), 12'($urandom));
      tick();
    end
    check("rst_hold_rgb", {8'd0, red_out, green_out, blue_out}, 0);
    check("rst_hold_syncs", {29'd0, hsync_out, vsync_out, de_out}, 32'h6);
    drive(0, 0, 0, 12'h000, 12'h000);
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("release_pulses", {30'd0, sof_out, timeout}, 0);
    end

    // Pixel decode, two back-to-back de pixels with hsync active.
    drive(1, 0, 1, 12'h5A3, 12'hC7E); tick();
    drive(1, 0, 1, 12'h3C9, 12'h81B); tick();
    check("dec0_red", {24'd0, red_out}, 32'hC7);
    check("dec0_green", {24'd0, green_out}, 32'hE5);
    check("dec0_blue", {24'd0, blue_out}, 32'hA3);
    check("dec0_ctrl", {28'd0, hsync_out, vsync_out, de_out, sof_out}, 32'h6);
    check("dec0_pix_x", {20'd0, pix_x}, 0);
    drive(0, 0, 0, 12'h000, 12'h000); tick();
    check("dec1_rgb", {8'd0, red_out, green_out, blue_out}, 32'h81B3C9);
    check("dec1_pix_x", {20'd0, pix_x}, 1);
    tick();
    check("dec2_ctrl", {29'd0, hsync_out, vsync_out, de_out}, 32'h6);

    // Mode measurement: 20/12/10/6.
    run_frame(20, 10, 0);
    run_frame(20, 10, 0);
    check_meas("mode_f2", 20, 12, 10, 6, 0);
    run_frame(20, 10, 0);
    check_meas("mode_f3", 20, 12, 10, 6, 0);
    run_frame(20, 10, 0);
    check_meas("mode_f4", 20, 12, 10, 6, 0);
    run_frame(20, 10, 1);
    check_meas("mode_f5", 20, 12, 10, 6, 1);

    // Mode change to 22-cycle lines.
    run_frame(22, 10, 0);
    check_meas("chg_f1", 20, 12, 10, 6, 1);
    run_frame(22, 10, 0);
    check_meas("chg_f2", 22, 12, 10, 6, 0);
    run_frame(22, 10, 0);
    check_meas("chg_f3", 22, 12, 10, 6, 0);
    run_frame(22, 10, 0);
    check_meas("chg_f4", 22, 12, 10, 6, 0);
    run_frame(22, 10, 1);
    check_meas("chg_f5", 22, 12, 10, 6, 1);

    // Loss of signal.
    pulses = 0; first_pulse = -1;
    for (int i = 0; i < 250; i++) begin
      drive(0, 0, 0, 12'h000, 12'h000); tick();
      if (timeout === 1'b1) begin
        if (pulses == 0) first_pulse = i;
        pulses++;
      end
    end
    check("los_pulses", pulses, 1);
    check("los_cycle", first_pulse, 80);
    check_meas("los", 0, 0, 0, 0, 0);

    // One hsync re-arms the detector.
    drive(1, 0, 0, 12'h000, 12'h000); tick();
    drive(1, 0, 0, 12'h000, 12'h000); tick();
    pulses = 0; first_pulse = -1;
    for (int i = 0; i < 150; i++) begin
      drive(0, 0, 0, 12'h000, 12'h000); tick();
      if (timeout === 1'b1) begin
        if (pulses == 0) first_pulse = i;
        pulses++;
      end
    end
    check("rearm_pulses", pulses, 1);
    check("rearm_cycle", first_pulse, 100);

    // Coincident hsync and vsync leading edges.
    run_frame(20, 0, 0);
    run_frame(20, 0, 0);
    check_meas("coin", 20, 12, 10, 6, 0);

    // Saturation: 5000-cycle hsync period on the long-timeout instance.
    drive(1, 0, 0, 12'h000, 12'h000); tick();
    drive(1, 0, 0, 12'h000, 12'h000); tick();
    repeat (4998) begin drive(0, 0, 0, 12'h000, 12'h000); tick(); end
    drive(1, 0, 0, 12'h000, 12'h000); tick();
    drive(1, 0, 0, 12'h000, 12'h000); tick();
    repeat (8) begin drive(0, 0, 0, 12'h000, 12'h000); tick(); end
    repeat (3) begin drive(0, 1, 0, 12'h000, 12'h000); tick(); end
    repeat (4) begin drive(0, 0, 0, 12'h000, 12'h000); tick(); end
    check("sat_h_total", {20'd0, h_total_s}, 32'hFFF);
    check("sat_h_active", {20'd0, h_active_s}, 12);
    check("sat_v_total", {20'd0, v_total_s}, 11);
    check("sat_timeout", {31'd0, timeout_s}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
